// File: rtl/stair_director.sv
// stair_director: frame-rate controller for the stair field.
// Decides per frame how far the field scrolls, which recycled stairs move or
// carry springs, accumulates score and detects game over.
module stair_director #(
  parameter logic [9:0]  SCROLL_LINE = 10'd160,
  parameter logic [9:0]  MAX_SCROLL  = 10'd4,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic             start,
  input  logic [9:0]       Player_Y,
  input  logic             land,
  input  logic [3:0]       land_idx,
  input  logic [13:0][9:0] Stair_Y,
  output logic [9:0]       distance,
  output logic [13:0]      move_message,
  output logic [13:0]      active_message,
  output logic [13:0]      tool_signal,
  output logic             spring_fire,
  output logic [15:0]      score,
  output logic             game_over
);

  typedef enum logic [1:0] {IDLE, RUN, SCROLL, OVER} state_t;

  localparam logic [9:0] BOTTOM_Y = 10'd479;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [9:0]  distance_q;
  logic [13:0] move_q;
  logic [13:0] active_q;
  logic [13:0] tool_q;
  logic        spring_q;
  logic [15:0] score_q;
  logic        over_q;
  logic [7:0]  cnt_q;

  // Combinational helpers feeding the frame FSM.
  logic [13:0] rec_mask;
  logic [13:0] rec_move;
  logic [13:0] rec_tool;
  logic [4:0]  rec_n;
  logic [1:0]  level;
  logic [3:0]  move_thresh;
  logic [8:0]  cnt_sum;
  logic [7:0]  cnt_d;
  logic [9:0]  scroll_diff;
  logic [9:0]  scroll_amt;
  logic [9:0]  scroll_dist;
  logic [16:0] score_sum;
  logic [15:0] score_d;
  logic [15:0] tool_pad;
  logic        spring_d;
  logic [13:0] tool_land;
  logic [13:0] tool_rec_d;
  logic [13:0] move_rec_d;
  logic        lfsr_fb;

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned n);
    logic [31:0] dbl;
    dbl = {v, v} << n;
    return dbl[31:16];
  endfunction

  // Free-running Fibonacci LFSR, taps 16/14/13/11.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge Clk) begin
    if (Reset) lfsr_q <= SEED;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  // Difficulty level derived from how many stairs have been recycled so far.
  always_comb begin
    level = 2'd0;
    if (cnt_q >= 8'd48)      level = 2'd3;
    else if (cnt_q >= 8'd32) level = 2'd2;
    else if (cnt_q >= 8'd16) level = 2'd1;
    move_thresh = {level, 2'b00};
  end

  // Recycle detection: each stair below the screen draws from the LFSR rotated by its index.
  always_comb begin
    logic [15:0] r;
    rec_mask = '0;
    rec_move = '0;
    rec_tool = '0;
    rec_n    = '0;
    r        = '0;
    for (int unsigned i = 0; i < 14; i++) begin
      rec_mask[i] = (Stair_Y[i] > BOTTOM_Y);
      r           = rotl16(lfsr_q, i);
      rec_move[i] = (r[3:0] < move_thresh);
      rec_tool[i] = (r[7:4] < 4'd3);
      rec_n       = rec_n + {4'd0, rec_mask[i]};
    end
    cnt_sum = {1'b0, cnt_q} + {4'd0, rec_n};
    cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // Scroll amount, its negated distance and the saturated score.
  always_comb begin
    scroll_diff = SCROLL_LINE - Player_Y;
    scroll_amt  = (scroll_diff > MAX_SCROLL) ? MAX_SCROLL : scroll_diff;
    scroll_dist = ~scroll_amt + 10'd1;
    score_sum   = {1'b0, score_q} + {7'd0, scroll_amt};
    score_d     = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Landing on a spring stair: pulse and consume the spring.
  always_comb begin
    tool_pad  = {2'b00, tool_q};
    spring_d  = land && (land_idx <= 4'd13) && tool_pad[land_idx];
    tool_land = tool_q;
    if (spring_d) tool_land[land_idx] = 1'b0;
    // A recycle on the same index overrides the landing clear.
    tool_rec_d = (tool_land & ~rec_mask) | (rec_tool & rec_mask);
    move_rec_d = (move_q & ~rec_mask) | (rec_move & rec_mask);
  end

  // Frame FSM with all registered outputs; only frame_tick advances it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      distance_q <= '0;
      move_q     <= '0;
      active_q   <= '1;
      tool_q     <= '0;
      spring_q   <= 1'b0;
      score_q    <= '0;
      over_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      spring_q <= spring_d;
      tool_q   <= tool_land;
      if (frame_tick) begin
        case (state_q)
          IDLE: begin
            distance_q <= '0;
            active_q   <= '1;
            if (start) state_q <= RUN;
          end
          RUN, SCROLL: begin
            move_q <= move_rec_d;
            tool_q <= tool_rec_d;
            cnt_q  <= cnt_d;
            if (Player_Y > BOTTOM_Y) begin
              state_q    <= OVER;
              distance_q <= '0;
              move_q     <= '0;
              active_q   <= '0;
              over_q     <= 1'b1;
            end else if (Player_Y < SCROLL_LINE) begin
              state_q    <= SCROLL;
              distance_q <= scroll_dist;
              score_q    <= score_d;
            end else begin
              state_q    <= RUN;
              distance_q <= '0;
            end
          end
          OVER: begin
            distance_q <= '0;
            move_q     <= '0;
            active_q   <= '0;
            if (start) begin
              state_q  <= IDLE;
              score_q  <= '0;
              cnt_q    <= '0;
              tool_q   <= '0;
              active_q <= '1;
              over_q   <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign distance       = distance_q;
  assign move_message   = move_q;
  assign active_message = active_q;
  assign tool_signal    = tool_q;
  assign spring_fire    = spring_q;
  assign score          = score_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_stair_director.sv
// Randomized bench for stair_director with a frame-level reference model.
module tb_stair_director;

  logic             Clk;
  logic             Reset;
  logic             frame_tick;
  logic             start;
  logic [9:0]       Player_Y;
  logic             land;
  logic [3:0]       land_idx;
  logic [13:0][9:0] Stair_Y;
  logic [9:0]       distance;
  logic [13:0]      move_message;
  logic [13:0]      active_message;
  logic [13:0]      tool_signal;
  logic             spring_fire;
  logic [15:0]      score;
  logic             game_over;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state; mode: 0 idle, 1 running, 2 scrolling, 3 over.
  int unsigned m_mode, m_lfsr, m_dist, m_move, m_act, m_tool, m_score, m_cnt;
  int unsigned m_spring, m_go;

  stair_director #(
    .SCROLL_LINE(10'd160),
    .MAX_SCROLL (10'd4),
    .SEED       (16'hACE1)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .start         (start),
    .Player_Y      (Player_Y),
    .land          (land),
    .land_idx      (land_idx),
    .Stair_Y       (Stair_Y),
    .distance      (distance),
    .move_message  (move_message),
    .active_message(active_message),
    .tool_signal   (tool_signal),
    .spring_fire   (spring_fire),
    .score         (score),
    .game_over     (game_over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rot16(input int unsigned v, input int unsigned n);
    return ((v << n) | (v >> (16 - n))) & 32'hFFFF;
  endfunction

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_edge();
    int unsigned old_lfsr, lvl, r, n, s, fb, nt, py;
    old_lfsr = m_lfsr;
    py = Player_Y;
    if (Reset) begin
      m_mode = 0; m_lfsr = 16'hACE1; m_dist = 0; m_move = 0; m_act = 14'h3FFF;
      m_tool = 0; m_spring = 0; m_score = 0; m_go = 0; m_cnt = 0;
      return;
    end
    fb = ((old_lfsr >> 15) ^ (old_lfsr >> 13) ^ (old_lfsr >> 12) ^ (old_lfsr >> 10)) & 1;
    m_lfsr = ((old_lfsr << 1) | fb) & 32'hFFFF;
    m_spring = (land && land_idx <= 13 && ((m_tool >> land_idx) & 1)) ? 1 : 0;
    nt = m_tool;
    if (m_spring != 0) nt = nt & ~(32'd1 << land_idx);
    if (frame_tick) begin
      if (m_mode == 0) begin
        if (start) m_mode = 1;
      end else if (m_mode == 1 || m_mode == 2) begin
        lvl = (m_cnt >= 48) ? 3 : (m_cnt >= 32) ? 2 : (m_cnt >= 16) ? 1 : 0;
        n = 0;
        for (int i = 0; i < 14; i++) begin
          if (Stair_Y[i] > 479) begin
            n++;
            r = rot16(old_lfsr, i);
            if ((r % 16) < lvl * 4) m_move = m_move | (32'd1 << i);
            else                    m_move = m_move & ~(32'd1 << i);
            if (((r / 16) % 16) < 3) nt = nt | (32'd1 << i);
            else                     nt = nt & ~(32'd1 << i);
          end
        end
        m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
        if (py > 479) begin
          m_mode = 3; m_dist = 0; m_move = 0; m_act = 0; m_go = 1;
        end else if (py < 160) begin
          s = (160 - py > 4) ? 4 : 160 - py;
          m_mode = 2;
          m_dist = (1024 - s) % 1024;
          m_score = (m_score + s > 65535) ? 65535 : m_score + s;
        end else begin
          m_mode = 1; m_dist = 0;
        end
      end else begin
        if (start) begin
          m_mode = 0; m_score = 0; m_cnt = 0; nt = 0; m_act = 14'h3FFF; m_go = 0;
        end
      end
    end
    m_tool = nt;
  endtask

  task automatic compare_all();
    check("distance", distance, m_dist);
    check("move_message", move_message, m_move);
    check("active_message", active_message, m_act);
    check("tool_signal", tool_signal, m_tool);
    check("spring_fire", spring_fire, m_spring);
    check("score", score, m_score);
    check("game_over", game_over, m_go);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic tick_frame(input logic [9:0] py, input logic st);
    Player_Y = py; start = st; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0; start = 1'b0;
    step();
  endtask

  task automatic stairs_all(input int unsigned y);
    for (int i = 0; i < 14; i++) Stair_Y[i] = 10'(y);
  endtask

  int unsigned k;
  logic        found;

  initial begin
    m_mode = 0; m_lfsr = 0; m_dist = 0; m_move = 0; m_act = 0; m_tool = 0;
    m_score = 0; m_cnt = 0; m_spring = 0; m_go = 0;
    Reset = 1'b1; frame_tick = 1'b0; start = 1'b0; Player_Y = 10'd300;
    land = 1'b0; land_idx = 4'd0;
    stairs_all(100);
    @(negedge Clk);
    step();
    step();
    check("rst_active", active_message, 14'h3FFF);
    check("rst_distance", distance, 10'd0);
    Reset = 1'b0;

    // Start, then the three-step scroll sequence.
    tick_frame(10'd300, 1'b1);
    check("run_distance", distance, 10'd0);
    check("run_active", active_message, 14'h3FFF);
    check("run_over", game_over, 1'b0);
    tick_frame(10'd150, 1'b0);
    check("scroll1_dist", distance, 10'h3FC);
    check("scroll1_score", score, 16'd4);
    tick_frame(10'd158, 1'b0);
    check("scroll2_dist", distance, 10'h3FE);
    check("scroll2_score", score, 16'd6);
    tick_frame(10'd200, 1'b0);
    check("scroll3_dist", distance, 10'd0);

    // Single recycle at level 0, then full-row recycles.
    Stair_Y[5] = 10'd500;
    tick_frame(10'd150, 1'b0);
    check("recycle_move5", move_message[5], 1'b0);
    stairs_all(100);
    found = 1'b0;
    for (int n = 0; n < 6 && !found; n++) begin
      stairs_all(600);
      tick_frame(10'd200, 1'b0);
      stairs_all(100);
      if (m_tool != 0) found = 1'b1;
    end

    // Landing on a spring stair, and an out-of-range index.
    if (found) begin
      k = 0;
      while (((m_tool >> k) & 1) == 0) k++;
      land = 1'b1; land_idx = 4'(k);
      step();
      land = 1'b0;
      check("spring_pulse", spring_fire, 1'b1);
      check("spring_clear", tool_signal[k], 1'b0);
      step();
      check("spring_width", spring_fire, 1'b0);
    end
    land = 1'b1; land_idx = 4'd14;
    step();
    land = 1'b0;
    check("land_idx14", spring_fire, 1'b0);

    // Game over and restart.
    tick_frame(10'd490, 1'b0);
    check("over_flag", game_over, 1'b1);
    check("over_active", active_message, 14'd0);
    check("over_dist", distance, 10'd0);
    tick_frame(10'd300, 1'b1);
    check("restart_score", score, 16'd0);
    check("restart_over", game_over, 1'b0);

    // Reset landing on a scroll tick wins over the scroll.
    tick_frame(10'd300, 1'b1);
    tick_frame(10'd150, 1'b0);
    Reset = 1'b1; frame_tick = 1'b1; Player_Y = 10'd150;
    step();
    Reset = 1'b0; frame_tick = 1'b0;
    check("rst_scroll_dist", distance, 10'd0);
    check("rst_scroll_score", score, 16'd0);

    // Randomized operation.
    for (int c = 0; c < 4000; c++) begin
      int unsigned sel;
      Reset      = ($urandom_range(0, 299) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      start      = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 99);
      if (sel < 40)      Player_Y = 10'($urandom_range(0, 159));
      else if (sel < 97) Player_Y = 10'($urandom_range(160, 479));
      else               Player_Y = 10'($urandom_range(480, 1023));
      for (int i = 0; i < 14; i++)
        Stair_Y[i] = ($urandom_range(0, 9) < 3) ? 10'($urandom_range(480, 1023))
                                                : 10'($urandom_range(0, 479));
      land     = ($urandom_range(0, 3) == 0);
      land_idx = 4'($urandom_range(0, 15));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stair_director.md
# stair_director

Frame-rate controller that drives the stair field's control inputs: `distance`, `move_message`, `active_message` and `tool_signal`. It reads back stair Y positions, the player's Y position and landing events, and decides several things per frame: when the screen scrolls, which recycled stairs move or carry springs, and when the game ends. It sits between the collision/player logic and the stair position block, in the same clock domain as the game logic.

## Interface
Parameters:
- SCROLL_LINE, 10'd160: player Y above which (smaller Y) the field scrolls down.
- MAX_SCROLL, 10'd4: maximum scroll pixels per frame.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-Clk-cycle pulse per video frame.
- start, in, 1: level-sampled start request.
- Player_Y, in, 10: player centre Y.
- land, in, 1: one-cycle pulse, player landed on a stair.
- land_idx, in, 4: index 0–13 of the landed stair; valid with `land`.
- Stair_Y, in, [13:0][9:0]: current stair centre Y.
- distance, out, 10: value the stair block subtracts from every Stair_Y each frame (two's complement).
- move_message, out, 14: per-stair horizontal-motion enable.
- active_message, out, 14: per-stair "respawn at top when recycled" enable.
- tool_signal, out, 14: per-stair spring present.
- spring_fire, out, 1: one-cycle pulse, player landed on a spring stair.
- score, out, 16: accumulated scroll pixels, saturating.
- game_over, out, 1: high while in the OVER state.

## Operation
- Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Steps every Clk.
  - Reset value is SEED.
- States: IDLE, RUN, SCROLL, OVER.
- IDLE:
  - distance=0, active_message=14'h3FFF.
  - start=1 at frame_tick → RUN.
- RUN:
  - distance=0.
  - At frame_tick: if Player_Y>479 → OVER; else if Player_Y<SCROLL_LINE → SCROLL and apply the scroll computation on this same tick.
- SCROLL:
  - At frame_tick: s = min(SCROLL_LINE−Player_Y, MAX_SCROLL); distance = (~s+1) mod 1024 (moves stairs down).
  - score += s, saturating at 16'hFFFF.
  - If Player_Y>=SCROLL_LINE: distance=0, → RUN.
  - If Player_Y>479: → OVER, which has priority.
- OVER:
  - distance=0, active_message=0, move_message=0.
  - start=1 at frame_tick → IDLE.
  - Leaving OVER clears score, recycle_cnt and tool_signal.
- Recycle detection, RUN/SCROLL only, at frame_tick, for each i with Stair_Y[i]>479:
  - r_i = LFSR rotated left by i.
  - move_message[i] = (r_i[3:0] < level*4).
  - tool_signal[i] = (r_i[7:4] < 4'd3).
- recycle_cnt (8-bit, saturating at 255) adds the number of stairs recycled that tick (0–14).
- level = 3 if recycle_cnt>=48, 2 if >=32, 1 if >=16, else 0. Level 0 never moves stairs.
- Landing: on land with land_idx<=13 and tool_signal[land_idx]=1:
  - spring_fire=1 for one cycle.
  - tool_signal[land_idx] cleared.
  - land_idx>13 is ignored.
- Simultaneous recycle and land on the same index in the same cycle: the recycle assignment wins and spring_fire still pulses.

## Timing
- distance, move_message, active_message, tool_signal, score and game_over update only on the Clk edge sampling frame_tick=1.
  - New values are visible the cycle after the tick and held for the whole frame.
- spring_fire is registered: asserts the cycle after land, exactly one cycle wide.
- Reset (synchronous, any state, any cycle, including the frame_tick cycle) sets the following on the next edge:
  - state=IDLE, distance=0, move_message=0, active_message=14'h3FFF, tool_signal=0.
  - spring_fire=0, score=0, game_over=0, recycle_cnt=0, LFSR=SEED.
- Inputs held without frame_tick produce no output change, except spring_fire and tool_signal clearing.

## Test plan
- Reset, then start=1 with frame_tick → state RUN; distance=0, active_message=14'h3FFF, game_over=0.
- RUN, Player_Y=150, frame_tick → distance=10'h3FC (−4), score=4. Next tick with Player_Y=158 → distance=10'h3FE, score=6. Next tick with Player_Y=200 → distance=0, state RUN.
- SCROLL, Stair_Y[5]=10'd500 with recycle_cnt=0 → move_message[5]=0; tool_signal[5] matches the rotated LFSR bits; recycle_cnt=1. Fourteen simultaneous recycles → recycle_cnt+=14.
- tool_signal[3]=1, land=1, land_idx=3 → spring_fire high for exactly one cycle, tool_signal[3]=0. land_idx=14 → no effect.
- Player_Y=490 at frame_tick → game_over=1, active_message=0, distance=0. start then → IDLE with score=0.
- Reset asserted during SCROLL on a frame_tick cycle → all outputs at their reset values the next cycle; the scroll is not applied.
